// File: rtl/fft_pkg.sv
// Shared word types and helpers for the sign-magnitude Q0.15 FFT datapath.
package fft_pkg;
  localparam int SM_W     = 16;
  localparam int MAG_W    = 15;
  localparam int SIGN_BIT = 15;

  typedef logic [SM_W-1:0] sm16_t;

  typedef struct packed {
    sm16_t re;
    sm16_t im;
  } cplx_t;

  function automatic sm16_t sm_neg(input sm16_t v);
    sm_neg = {~v[SIGN_BIT], v[MAG_W-1:0]};
  endfunction

  // Truncating divide-by-2 of the magnitude; the sign (including -0) is preserved.
  function automatic sm16_t sm_half(input sm16_t v);
    sm_half = {v[SIGN_BIT], 1'b0, v[MAG_W-1:1]};
  endfunction
endpackage

// File: rtl/fixed_point_add.sv
// Combinational sign-magnitude Q0.15 add; like signs wrap mod 2^15, unlike signs subtract.
// A tie between unlike signs yields zero carrying the second operand's sign.
module fixed_point_add
  import fft_pkg::*;
(
  input  logic [SM_W-1:0] a,
  input  logic [SM_W-1:0] b,
  output logic [SM_W-1:0] sum
);
  logic [MAG_W-1:0] ma;
  logic [MAG_W-1:0] mb;

  assign ma = a[MAG_W-1:0];
  assign mb = b[MAG_W-1:0];

  always_comb begin
    sum = '0;
    if (a[SIGN_BIT] == b[SIGN_BIT]) begin
      sum = {a[SIGN_BIT], ma + mb};
    end else if (ma > mb) begin
      sum = {a[SIGN_BIT], ma - mb};
    end else begin
      sum = {b[SIGN_BIT], mb - ma};
    end
  end
endmodule

// File: rtl/sm_mult.sv
// Combinational sign-magnitude Q0.15 multiply, magnitude truncated to bits 29:15.
// Zero products keep the XOR sign so -0 can appear.
module sm_mult
  import fft_pkg::*;
(
  input  logic [SM_W-1:0] a,
  input  logic [SM_W-1:0] b,
  output logic [SM_W-1:0] p
);
  logic [2*MAG_W-1:0] ma;
  logic [2*MAG_W-1:0] mb;
  logic [2*MAG_W-1:0] prod;

  assign ma   = {{MAG_W{1'b0}}, a[MAG_W-1:0]};
  assign mb   = {{MAG_W{1'b0}}, b[MAG_W-1:0]};
  assign prod = ma * mb;
  assign p    = {a[SIGN_BIT] ^ b[SIGN_BIT], prod[2*MAG_W-1:MAG_W]};
endmodule

// File: rtl/fft_butterfly_pipe.sv
// Radix-2 DIT butterfly X = A + W*B, Y = A - W*B on sign-magnitude Q0.15, optional /2 per stage.
// 3-cycle latency, 1 vector/cycle; one global enable freezes every stage while the result is refused.
module fft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter bit SCALE = 1'b1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SM_W-1:0] a_re,
  input  logic [SM_W-1:0] a_im,
  input  logic [SM_W-1:0] b_re,
  input  logic [SM_W-1:0] b_im,
  input  logic [SM_W-1:0] w_re,
  input  logic [SM_W-1:0] w_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SM_W-1:0] x_re,
  output logic [SM_W-1:0] x_im,
  output logic [SM_W-1:0] y_re,
  output logic [SM_W-1:0] y_im
);
  logic  en;
  logic  v1, v2, v3;
  cplx_t a_in, a1, a2, x_q, y_q;
  sm16_t rr_c, ii_c, ri_c, ir_c;
  sm16_t rr1, ii1, ri1, ir1;
  sm16_t neg_ii1;
  cplx_t p_c, p2;
  cplx_t a_s, p_s, neg_p_s, x_c, y_c;

  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;
  assign a_in      = '{re: a_re, im: a_im};

  sm_mult u_mul_rr (.a(w_re), .b(b_re), .p(rr_c));
  sm_mult u_mul_ii (.a(w_im), .b(b_im), .p(ii_c));
  sm_mult u_mul_ri (.a(w_re), .b(b_im), .p(ri_c));
  sm_mult u_mul_ir (.a(w_im), .b(b_re), .p(ir_c));

  // Complex product W*B; operand order fixes the sign of zero results.
  assign neg_ii1 = sm_neg(ii1);
  fixed_point_add u_add_pre (.a(rr1), .b(neg_ii1), .sum(p_c.re));
  fixed_point_add u_add_pim (.a(ri1), .b(ir1),     .sum(p_c.im));

  always_comb begin
    a_s = a2;
    p_s = p2;
    if (SCALE) begin
      a_s = '{re: sm_half(a2.re), im: sm_half(a2.im)};
      p_s = '{re: sm_half(p2.re), im: sm_half(p2.im)};
    end
  end

  assign neg_p_s = '{re: sm_neg(p_s.re), im: sm_neg(p_s.im)};

  fixed_point_add u_add_xre (.a(a_s.re), .b(p_s.re),     .sum(x_c.re));
  fixed_point_add u_add_xim (.a(a_s.im), .b(p_s.im),     .sum(x_c.im));
  fixed_point_add u_add_yre (.a(a_s.re), .b(neg_p_s.re), .sum(y_c.re));
  fixed_point_add u_add_yim (.a(a_s.im), .b(neg_p_s.im), .sum(y_c.im));

  // Bubbles travel with the data and are never collapsed while stalled.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      a1  <= '0;
      rr1 <= '0;
      ii1 <= '0;
      ri1 <= '0;
      ir1 <= '0;
      a2  <= '0;
      p2  <= '0;
      x_q <= '0;
      y_q <= '0;
    end else if (en) begin
      v1  <= in_valid;
      v2  <= v1;
      v3  <= v2;
      a1  <= a_in;
      rr1 <= rr_c;
      ii1 <= ii_c;
      ri1 <= ri_c;
      ir1 <= ir_c;
      a2  <= a1;
      p2  <= p_c;
      x_q <= x_c;
      y_q <= y_c;
    end
  end

  assign x_re = x_q.re;
  assign x_im = x_q.im;
  assign y_re = y_q.re;
  assign y_im = y_q.im;
endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Bench for fft_butterfly_pipe: both SCALE settings driven in lockstep against an arithmetic reference.
module tb_fft_butterfly_pipe;
  logic clk = 1'b0;
  logic n_rst;
  logic in_valid, out_ready;
  logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic in_ready0, out_valid0, in_ready1, out_valid1;
  logic [15:0] x_re0, x_im0, y_re0, y_im0;
  logic [15:0] x_re1, x_im1, y_re1, y_im1;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_lat  = 1'b0;
  bit use_dir  = 1'b0;
  logic [127:0] dir_exp = '0;
  logic [127:0] qexp[$];
  int qacc[$];

  fft_butterfly_pipe #(.SCALE(1'b0)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid0), .out_ready(out_ready),
    .x_re(x_re0), .x_im(x_im0), .y_re(y_re0), .y_im(y_im0)
  );

  fft_butterfly_pipe #(.SCALE(1'b1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid1), .out_ready(out_ready),
    .x_re(x_re1), .x_im(x_im1), .y_re(y_re1), .y_im(y_im1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference arithmetic straight from the number-format rules.
  function automatic logic [15:0] r_mul(input logic [15:0] a, input logic [15:0] b);
    int unsigned ma, mb, p;
    ma = {17'b0, a[14:0]};
    mb = {17'b0, b[14:0]};
    p  = ma * mb;
    return {a[15] ^ b[15], p[29:15]};
  endfunction

  function automatic logic [15:0] r_add(input logic [15:0] a, input logic [15:0] b);
    int unsigned ma, mb;
    logic s;
    logic [14:0] m;
    ma = {17'b0, a[14:0]};
    mb = {17'b0, b[14:0]};
    if (a[15] == b[15]) begin
      s = a[15]; m = 15'((ma + mb) % 32768);
    end else if (ma > mb) begin
      s = a[15]; m = 15'(ma - mb);
    end else if (mb > ma) begin
      s = b[15]; m = 15'(mb - ma);
    end else begin
      s = b[15]; m = 15'd0;
    end
    return {s, m};
  endfunction

  function automatic logic [15:0] r_neg(input logic [15:0] v);
    return {~v[15], v[14:0]};
  endfunction

  function automatic logic [15:0] r_scl(input logic [15:0] v, input bit s);
    int unsigned m;
    m = {17'b0, v[14:0]};
    if (s) m = m / 2;
    return {v[15], 15'(m)};
  endfunction

  function automatic logic [63:0] r_out(input logic [15:0] ar, input logic [15:0] ai,
                                        input logic [15:0] pr, input logic [15:0] pi, input bit s);
    logic [15:0] sar, sai, spr, spi;
    sar = r_scl(ar, s); sai = r_scl(ai, s);
    spr = r_scl(pr, s); spi = r_scl(pi, s);
    return {r_add(sar, spr), r_add(sai, spi), r_add(sar, r_neg(spr)), r_add(sai, r_neg(spi))};
  endfunction

  function automatic logic [127:0] ref_bfly(input logic [15:0] ar, input logic [15:0] ai,
                                            input logic [15:0] br, input logic [15:0] bi,
                                            input logic [15:0] wr, input logic [15:0] wi);
    logic [15:0] pr, pi;
    pr = r_add(r_mul(wr, br), r_neg(r_mul(wi, bi)));
    pi = r_add(r_mul(wr, bi), r_mul(wi, br));
    return {r_out(ar, ai, pr, pi, 1'b0), r_out(ar, ai, pr, pi, 1'b1)};
  endfunction

  function automatic logic [15:0] rword();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rnd_in();
    a_re = rword(); a_im = rword();
    b_re = rword(); b_im = rword();
    w_re = rword(); w_im = rword();
  endtask

  // One cycle: called at a falling edge with inputs already driven.
  task automatic step();
    logic [127:0] obs;
    #1;
    chk("in_ready0", 128'(in_ready0), 128'(!out_valid0 || out_ready));
    chk("in_ready1", 128'(in_ready1), 128'(!out_valid1 || out_ready));
    if (out_valid0) begin
      chk("no_spurious", 128'(qexp.size() > 0), 128'(1));
      if (qexp.size() > 0) begin
        obs = {x_re0, x_im0, y_re0, y_im0, x_re1, x_im1, y_re1, y_im1};
        chk("res_scale0", 128'(obs[127:64]), 128'(qexp[0][127:64]));
        chk("res_scale1", 128'(obs[63:0]), 128'(qexp[0][63:0]));
        if (chk_lat) chk("latency", 128'(cyc - qacc[0]), 128'(3));
        if (out_ready) begin
          void'(qexp.pop_front());
          void'(qacc.pop_front());
        end
      end
    end
    if (in_valid && in_ready0) begin
      qexp.push_back(use_dir ? dir_exp : ref_bfly(a_re, a_im, b_re, b_im, w_re, w_im));
      qacc.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic send_dir(input logic [15:0] ar, input logic [15:0] ai, input logic [15:0] br,
                          input logic [15:0] bi, input logic [15:0] wr, input logic [15:0] wi,
                          input logic [127:0] e);
    a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
    in_valid = 1'b1; use_dir = 1'b1; dir_exp = e;
    step();
    in_valid = 1'b0; use_dir = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && qexp.size() > 0; i++) step();
    chk("drained", 128'(qexp.size()), 128'(0));
    step();
    step();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 128'({out_valid0, out_valid1}), 128'(0));
    chk({tag, "_ready"}, 128'({in_ready0, in_ready1}), 128'(3));
    chk({tag, "_data"}, {x_re0, x_im0, y_re0, y_im0, x_re1, x_im1, y_re1, y_im1}, 128'(0));
  endtask

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    #2;
    chk_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Directed: truncation, signed zeros, wrap versus scaling.
    chk_lat = 1'b1;
    send_dir(16'h2000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000,
             {16'h3FFF, 16'h0000, 16'h0001, 16'h8000, 16'h1FFF, 16'h0000, 16'h0001, 16'h8000});
    send_dir(16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'hFFFF,
             {16'h0000, 16'hBFFF, 16'h8000, 16'h3FFF, 16'h0000, 16'h9FFF, 16'h8000, 16'h1FFF});
    send_dir(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000,
             {16'h5FFF, 16'h0000, 16'h0001, 16'h8000, 16'h6FFF, 16'h0000, 16'h0001, 16'h8000});
    drain();

    // Streaming: 8 back-to-back vectors.
    for (int i = 0; i < 8; i++) begin
      rnd_in(); in_valid = 1'b1; step();
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: 3 accepted, a 4th held by upstream across a 5-cycle stall.
    chk_lat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd_in(); in_valid = 1'b1; step();
    end
    rnd_in();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready_low", 128'(in_ready0), 128'(0));
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with vectors in flight.
    chk_lat = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rnd_in(); in_valid = 1'b1; step();
    end
    in_valid = 1'b0;
    step();
    #2 n_rst = 1'b0;
    #1;
    chk_reset_state("async_rst");
    qexp.delete();
    qacc.delete();
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rnd_in(); in_valid = 1'b1; step();
    in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure.
    chk_lat = 1'b0;
    for (int i = 0; i < 80; i++) begin
      rnd_in();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
